// File: rtl/add_sub_bist_if.sv
// Bus between the add/sub built-in self test and its environment:
// run control/status plus the operand/result lines of the unit under test.
interface add_sub_bist_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 17
);
   logic             start;
   logic             busy;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] err_count;
   logic [CNT_W-1:0] first_fail_idx;
   logic [WIDTH-1:0] dut_a;
   logic [WIDTH-1:0] dut_b;
   logic             dut_subtract;
   logic [WIDTH-1:0] dut_sum;
   logic             dut_cout;

   modport master (
      input  start,
      output busy, done, pass, err_count, first_fail_idx,
      output dut_a, dut_b, dut_subtract,
      input  dut_sum, dut_cout
   );

   modport slave (
      output start,
      input  busy, done, pass, err_count, first_fail_idx,
      input  dut_a, dut_b, dut_subtract,
      output dut_sum, dut_cout
   );
endinterface

// File: rtl/add_sub_bist.sv
// Built-in self test for the combinational add_and_subtract unit: LFSR operands,
// each pair checked in add then subtract mode against a golden model.
module add_sub_bist #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned NUM_VECTORS = 100,
   parameter int unsigned CNT_W       = 17,
   parameter logic [31:0] SEED_A      = 32'hBD40_1A21,
   parameter logic [31:0] SEED_B      = 32'hECD9_1CD1
) (
   input logic            clk,
   input logic            rst_n,
   add_sub_bist_if.master bus
);

   localparam logic [WIDTH-1:0] TAPS     = WIDTH'(32'h8020_0003);
   localparam logic [WIDTH-1:0] SEED_A_W = WIDTH'(SEED_A);
   localparam logic [WIDTH-1:0] SEED_B_W = WIDTH'(SEED_B);
   // A zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [WIDTH-1:0] INIT_A   = (SEED_A_W == '0) ? WIDTH'(1) : SEED_A_W;
   localparam logic [WIDTH-1:0] INIT_B   = (SEED_B_W == '0) ? WIDTH'(1) : SEED_B_W;
   localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(NUM_VECTORS - 1);

   typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] lfsr_a, lfsr_a_next, lfsr_b, lfsr_b_next;
   logic [CNT_W-1:0] vec, vec_next;
   logic             sub, sub_next;
   logic             failed, failed_next;
   logic             busy_q, busy_next, done_q, done_next, pass_q, pass_next;
   logic [CNT_W-1:0] err_q, err_next, err_after;
   logic [CNT_W-1:0] ffi_q, ffi_next;
   logic [WIDTH-1:0] a_q, a_next, b_q, b_next;
   logic             s_q, s_next;
   logic [WIDTH:0]   golden;
   logic             mismatch;

   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] x);
      return (x >> 1) ^ (x[0] ? TAPS : '0);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         lfsr_a <= INIT_A;
         lfsr_b <= INIT_B;
         vec    <= '0;
         sub    <= 1'b0;
         failed <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         pass_q <= 1'b0;
         err_q  <= '0;
         ffi_q  <= '1;
         a_q    <= '0;
         b_q    <= '0;
         s_q    <= 1'b0;
      end else begin
         state  <= state_next;
         lfsr_a <= lfsr_a_next;
         lfsr_b <= lfsr_b_next;
         vec    <= vec_next;
         sub    <= sub_next;
         failed <= failed_next;
         busy_q <= busy_next;
         done_q <= done_next;
         pass_q <= pass_next;
         err_q  <= err_next;
         ffi_q  <= ffi_next;
         a_q    <= a_next;
         b_q    <= b_next;
         s_q    <= s_next;
      end
   end

   always_comb begin
      state_next  = state;
      lfsr_a_next = lfsr_a;
      lfsr_b_next = lfsr_b;
      vec_next    = vec;
      sub_next    = sub;
      failed_next = failed;
      busy_next   = busy_q;
      done_next   = done_q;
      pass_next   = pass_q;
      err_next    = err_q;
      ffi_next    = ffi_q;
      a_next      = a_q;
      b_next      = b_q;
      s_next      = s_q;

      // Subtract carry is that of a + ~b + 1, i.e. set when a >= b.
      if (s_q) golden = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
      else     golden = {1'b0, a_q} + {1'b0, b_q};
      mismatch  = ({bus.dut_cout, bus.dut_sum} != golden);
      err_after = err_q;
      if (mismatch && (err_q != '1)) err_after = err_q + CNT_W'(1);

      case (state)
         IDLE, DONE: begin
            if (bus.start) begin
               state_next  = DRIVE;
               busy_next   = 1'b1;
               done_next   = 1'b0;
               pass_next   = 1'b0;
               err_next    = '0;
               ffi_next    = '1;
               failed_next = 1'b0;
               vec_next    = '0;
               sub_next    = 1'b0;
               lfsr_a_next = INIT_A;
               lfsr_b_next = INIT_B;
            end
         end
         DRIVE: begin
            a_next     = lfsr_a;
            b_next     = lfsr_b;
            s_next     = sub;
            state_next = CHECK;
         end
         CHECK: begin
            err_next = err_after;
            if (mismatch && !failed) begin
               failed_next = 1'b1;
               ffi_next    = {vec[CNT_W-2:0], sub};
            end
            if (!sub) begin
               sub_next   = 1'b1;
               state_next = DRIVE;
            end else if (vec < LAST_VEC) begin
               sub_next    = 1'b0;
               vec_next    = vec + CNT_W'(1);
               lfsr_a_next = lfsr_step(lfsr_a);
               lfsr_b_next = lfsr_step(lfsr_b);
               state_next  = DRIVE;
            end else begin
               state_next = DONE;
               busy_next  = 1'b0;
               done_next  = 1'b1;
               pass_next  = (err_after == '0);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.pass           = pass_q;
   assign bus.err_count      = err_q;
   assign bus.first_fail_idx = ffi_q;
   assign bus.dut_a          = a_q;
   assign bus.dut_b          = b_q;
   assign bus.dut_subtract   = s_q;

endmodule
